traffic_light_ctrl: RTL and testbench

- Single-intersection traffic-light sequencer: RED -> GREEN -> YELLOW -> RED, repeating forever.
- Each phase lasts a parameterised number of clock cycles.
- An optional pedestrian request ends GREEN early, after a minimum green time.
- Drives a one-hot lamp bus to the light drivers and exposes the current phase for status and debug.

---
 rtl/traffic_light_pkg.sv | 24 ++
 rtl/traffic_phase_timer.sv | 22 ++
 rtl/traffic_light_ctrl.sv | 96 +++++++++
 tb/tb_traffic_light_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared phase encoding and lamp constants for the traffic light controller.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } phase_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // The unused code 3 shows red so the lamps stay one-hot while the FSM recovers.
  function automatic logic [2:0] phase_to_light(input logic [1:0] p);
    case (p)
      RED:     phase_to_light = LIGHT_RED;
      GREEN:   phase_to_light = LIGHT_GREEN;
      YELLOW:  phase_to_light = LIGHT_YELLOW;
      default: phase_to_light = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase up-counter: cleared on phase entry, flags done at the terminal count.
module traffic_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  assign done = (cnt == term);

  // Holding at the terminal count means the counter can never wrap inside a phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   cnt <= '0;
    else if (clear) cnt <= '0;
    else if (!done) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Single-intersection RED -> GREEN -> YELLOW sequencer with pedestrian early-end of GREEN.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = 5,
  parameter int GREEN_CYCLES  = 4,
  parameter int YELLOW_CYCLES = 2,
  parameter int MIN_GREEN     = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ped_req,
  output logic [2:0] light,
  output logic [1:0] phase,
  output logic       ped_pending
);

  localparam int MAX_DUR = (RED_CYCLES > GREEN_CYCLES)
                         ? ((RED_CYCLES > YELLOW_CYCLES) ? RED_CYCLES : YELLOW_CYCLES)
                         : ((GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES);

  generate
    if (RED_CYCLES < 1 || GREEN_CYCLES < 1 || YELLOW_CYCLES < 1) begin : g_bad_dur
      $error("traffic_light_ctrl: phase durations must be >= 1");
    end
    if (MIN_GREEN < 1 || MIN_GREEN > GREEN_CYCLES) begin : g_bad_min
      $error("traffic_light_ctrl: MIN_GREEN must be in 1..GREEN_CYCLES");
    end
    if (CNT_W < 1 || CNT_W > 31 || (MAX_DUR - 1) >= (1 << CNT_W)) begin : g_bad_w
      $error("traffic_light_ctrl: CNT_W too small for longest phase");
    end
  endgenerate

  localparam logic [CNT_W-1:0] RED_T    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_T  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_T = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_T    = CNT_W'(MIN_GREEN - 1);

  phase_t           phase_q, phase_d;
  logic             pend_d;
  logic             clear;
  logic [CNT_W-1:0] term, cnt;
  logic             done;

  traffic_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .term    (term),
    .cnt     (cnt),
    .done    (done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= RED;
      ped_pending <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      ped_pending <= pend_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    term    = '0;
    case (phase_q)
      RED: begin
        term = RED_T;
        if (done) phase_d = GREEN;
      end
      GREEN: begin
        term = GREEN_T;
        if (done || ((ped_req || ped_pending) && cnt >= MIN_T)) phase_d = YELLOW;
      end
      YELLOW: begin
        term = YELLOW_T;
        if (done) phase_d = RED;
      end
      default: phase_d = RED;
    endcase
    // Any phase change (including recovery from code 3) restarts the timer.
    clear = (phase_d != phase_q);
    // A request is consumed by the GREEN->YELLOW edge, never latched on it.
    if (phase_q == GREEN && phase_d == YELLOW) pend_d = 1'b0;
    else if (ped_req)                          pend_d = 1'b1;
    else                                       pend_d = ped_pending;
  end

  always_comb begin
    light = phase_to_light(phase_q);
    phase = phase_q;
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl at default parameters.
module tb_traffic_light_ctrl;

  localparam logic [1:0] P_R = 2'd0, P_G = 2'd1, P_Y = 2'd2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] light;
  logic [1:0] phase;
  logic       ped_pending;
  int         checks = 0;
  int         errors = 0;

  traffic_light_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ped_req     (ped_req),
    .light       (light),
    .phase       (phase),
    .ped_pending (ped_pending)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] lamp(input logic [1:0] p);
    case (p)
      P_G:     lamp = 3'b001;
      P_Y:     lamp = 3'b010;
      default: lamp = 3'b100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic state(input string tag, input logic [1:0] ep, input logic epend);
    chk({tag, ".phase"}, {2'b00, phase}, {2'b00, ep});
    chk({tag, ".light"}, {1'b0, light}, {1'b0, lamp(ep)});
    chk({tag, ".pend"},  {3'b000, ped_pending}, {3'b000, epend});
  endtask

  // One rising edge, then sample 1 ns later.
  task automatic cyc(input string tag, input logic [1:0] ep, input logic epend);
    @(posedge clock);
    #1;
    state(tag, ep, epend);
  endtask

  task automatic seg(input string tag, input logic [1:0] ep, input int n, input logic epend);
    for (int i = 0; i < n; i++) cyc(tag, ep, epend);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: outputs at reset values, including across an edge.
    #1;  state("rst", P_R, 1'b0);
    @(posedge clock); #1;
    state("rst_hold", P_R, 1'b0);
    #6 reset_n = 1'b1;

    // Free run: RED after edges 1-4, GREEN from edge 5, YELLOW from edge 9, RED from edge 11.
    seg("run_r0", P_R, 4, 1'b0);
    for (int p = 0; p < 2; p++) begin
      seg("run_g", P_G, 4, 1'b0);
      seg("run_y", P_Y, 2, 1'b0);
      seg("run_r", P_R, 5, 1'b0);
    end

    // Async reset mid-GREEN takes effect before the next edge.
    seg("mid_g", P_G, 2, 1'b0);
    #2 reset_n = 1'b0;
    #1 state("async_rst", P_R, 1'b0);
    @(posedge clock); #1;
    state("async_hold", P_R, 1'b0);
    #3 reset_n = 1'b1;
    seg("post_rst_r", P_R, 4, 1'b0);

    // Pulse during GREEN cnt 0: GREEN shortened to 2 cycles.
    cyc("pg_g0", P_G, 1'b0);
    ped_req = 1'b1;
    cyc("pg_g1", P_G, 1'b1);
    ped_req = 1'b0;
    seg("pg_y", P_Y, 2, 1'b0);
    cyc("pr_r0", P_R, 1'b0);

    // Pulse during RED: RED unchanged, next GREEN 2 cycles.
    ped_req = 1'b1;
    cyc("pr_r1", P_R, 1'b1);
    ped_req = 1'b0;
    seg("pr_r", P_R, 3, 1'b1);
    seg("pr_g", P_G, 2, 1'b1);
    seg("pr_y", P_Y, 2, 1'b0);
    seg("pr_r2", P_R, 5, 1'b0);

    // Held request: steady 9-cycle period.
    ped_req = 1'b1;
    for (int p = 0; p < 2; p++) begin
      seg("hold_g", P_G, 2, 1'b1);
      cyc("hold_y0", P_Y, 1'b0);
      cyc("hold_y1", P_Y, 1'b1);
      seg("hold_r", P_R, 5, 1'b1);
    end
    ped_req = 1'b0;
    seg("rel_g", P_G, 2, 1'b1);
    seg("rel_y", P_Y, 2, 1'b0);
    seg("rel_r", P_R, 5, 1'b0);

    // Request only on the natural GREEN timeout edge: consumed, not latched.
    seg("late_g", P_G, 4, 1'b0);
    ped_req = 1'b1;
    cyc("late_y0", P_Y, 1'b0);
    ped_req = 1'b0;
    cyc("late_y1", P_Y, 1'b0);
    seg("late_r", P_R, 5, 1'b0);
    seg("late_g2", P_G, 4, 1'b0);
    seg("late_y2", P_Y, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
